// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-bit synchronizer, stability-count debouncer and press/release pulse generator
module button_debouncer #(
    parameter int width_p         = 3,
    parameter int stable_cycles_p = 12000
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] button_async_unsafe_i,
    output logic [width_p-1:0] button_o,
    output logic [width_p-1:0] press_o,
    output logic [width_p-1:0] release_o
);

    localparam int CW = $clog2(stable_cycles_p);
    localparam logic [CW-1:0] CNT_MAX = CW'(stable_cycles_p - 1);

    logic [width_p-1:0] r_sync1;
    logic [width_p-1:0] r_sync2;
    logic [width_p-1:0] r_stable;
    logic [width_p-1:0] r_press;
    logic [width_p-1:0] r_release;
    logic [CW-1:0]      r_cnt [width_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_stable  <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < width_p; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= button_async_unsafe_i;
            r_sync2 <= r_sync1;
            for (int i = 0; i < width_p; i++) begin
                r_press[i]   <= 1'b0;
                r_release[i] <= 1'b0;
                // Any sample agreeing with the current level restarts the count.
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i]  <= r_sync2[i];
                    r_cnt[i]     <= '0;
                    r_press[i]   <= r_sync2[i];
                    r_release[i] <= ~r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign button_o  = r_stable;
    assign press_o   = r_press;
    assign release_o = r_release;

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Per-button input conditioner for the icebreaker top level. Synchronizes the raw asynchronous, bouncing push-button inputs to the system clock, rejects bounce with a per-bit stability counter, and produces a clean debounced level plus single-cycle press/release pulses. Sits directly upstream of `uart_axi`, whose `buttons_i` bus it drives in place of the raw `button_async_unsafe_i` pins.

## Interface
- `width_p`, default 3: number of independent buttons.
- `stable_cycles_p`, default 12000: consecutive cycles a synchronized input must differ from the debounced level before the level is updated (1 ms at 12 MHz). Legal range is ≥ 2.
- `clk_i`, input, 1: the single clock (12 MHz board clock).
- `reset_n_i`, input, 1: reset, **asynchronous, active-low**. Asserting it clears all state immediately. Deassertion is already synchronized upstream.
- `button_async_unsafe_i`, input, `width_p`: raw button pins. Active-high, asynchronous, not debounced.
- `button_o`, output, `width_p`: debounced, registered button level.
- `press_o`, output, `width_p`: one-cycle pulse per bit on each debounced 0→1 transition.
- `release_o`, output, `width_p`: one-cycle pulse per bit on each debounced 1→0 transition.

## Operation
- Each bit is fully independent. No cross-bit interaction.
- **Synchronizer:** two-flop chain per bit, `sync1_r` then `sync2_r`. Only `sync2_r` is used downstream.
- **Counter:** one counter per bit, width `$clog2(stable_cycles_p)`, unsigned. It never exceeds `stable_cycles_p-1`, so it never wraps.
- **Per-bit state:** the debounced level `stable_r` (which drives `button_o`) and `cnt_r`. Each clock edge, in priority order:
  1. If `sync2_r == stable_r`: set `cnt_r` to 0. Outputs unchanged.
  2. Else if `cnt_r == stable_cycles_p-1`: set `stable_r` to `sync2_r` and `cnt_r` to 0. Pulse `press_o` if the new level is 1, or `release_o` if it is 0.
  3. Else: increment `cnt_r`.
- **Effect:** the level changes only after `sync2_r` has differed from `stable_r` on exactly `stable_cycles_p` consecutive edges. Any single matching sample (a bounce) restarts the count from 0.
- **Pulses:** `press_o` and `release_o` are registered and reload every cycle. They are high for exactly the one cycle in which `button_o` first shows the new level. They are never both high on the same bit.
- **Reset:** clears synchronizer flops, `stable_r`, `cnt_r`, `press_o` and `release_o` to 0. This means buttons are treated as released.
  - A button held through reset produces a `press_o` pulse once debounced after reset release.
- **Reset mid-count:** the count is discarded. No pulse is emitted.

## Timing
- Reset values: `button_o=0`, `press_o=0`, `release_o=0`. These take effect asynchronously on `reset_n_i` falling.
- Latency from a clean input step (settled before edge E0) to `button_o` changing: `stable_cycles_p+2` edges. The new level is visible after edge `E0+stable_cycles_p+1`.
  - 2 cycles of synchronizer.
  - `stable_cycles_p` cycles of counting.
- The pulse is coincident with the first cycle of the new `button_o` level. Its width is always 1 cycle.
- The minimum input pulse that propagates is `stable_cycles_p` cycles. Glitches shorter than that are fully suppressed, whatever their frequency.
- The maximum toggle rate of `button_o` is once per `stable_cycles_p` cycles.

## Test plan
All scenarios use `width_p=3` and `stable_cycles_p=4` unless noted.
- **Reset:** hold `reset_n_i=0` with inputs at `3'b111`, toggling the clock → all outputs 0. Release reset → `button_o` becomes `3'b111` after 6 edges, with `press_o=3'b111` for exactly that one cycle.
- **Clean press/release on bit 0:**
  - Drive 1 for 20 cycles → `button_o[0]` rises 6 edges after the input change, and `press_o[0]` pulses 1 cycle.
  - Drive 0 → `button_o[0]` falls 6 edges later, and `release_o[0]` pulses 1 cycle.
- **Bounce rejection:** on bit 1, drive the pattern 1,1,1,0,1,1,1,0 repeated for 40 cycles → `button_o[1]` stays 0 and no pulses occur. Then hold at 1 → the press is registered 6 edges after the last 0.
- **Independence:** press bit 2 while bit 0 is bouncing → only `button_o[2]` and `press_o[2]` respond, with correct latency.
- **Mid-count reset:** hold bit 0 at 1 for 4 cycles, pulse `reset_n_i` low for 1 cycle → no `press_o` during or immediately after the reset. The press registers 6 edges after reset release.
- **Default parameters:** hold a button 12001+ cycles → exactly one `press_o` pulse. A 11999-cycle press → no pulse.
